// File: rtl/mul_share_pkg.sv
// Shared types for the multiplier-sharing arbiter: requester id and the
// response register layout (id, product, valid).
package mul_share_pkg;

  localparam int unsigned DEF_DATA_WIDTH     = 16;
  localparam int unsigned DEF_PIPELINE_DEPTH = 4;
  localparam int unsigned DEF_NUM_REQ        = 4;

  localparam int unsigned ID_WIDTH     = $clog2(DEF_NUM_REQ);
  localparam int unsigned RESULT_WIDTH = 2 * DEF_DATA_WIDTH;

  typedef logic [ID_WIDTH-1:0] id_t;

  typedef struct packed {
    id_t                     id;
    logic [RESULT_WIDTH-1:0] result;
    logic                    valid;
  } rsp_t;

endpackage

// File: rtl/mul_rr_arbiter.sv
// Round-robin grant: search starts at ptr_i, first requesting index wins; one-hot output.
module mul_rr_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned PTR_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [PTR_WIDTH-1:0] ptr_i,
  input  logic                 en_i,
  output logic [NUM_REQ-1:0]   grant_o
);

  logic                 found;
  logic [PTR_WIDTH-1:0] idx;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    if (en_i) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        idx = PTR_WIDTH'((32'(ptr_i) + i) % NUM_REQ);
        if (!found && req_i[idx]) begin
          grant_o[idx] = 1'b1;
          found        = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pipelined_long_multiplier.sv
// Unsigned multiplier that folds DATA_WIDTH/PIPELINE_DEPTH bits of B per step;
// PIPELINE_DEPTH-2 register stages, final step combinational into the consumer's register.
module pipelined_long_multiplier #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned PIPELINE_DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    clk_en_i,
  input  logic                    valid_entry_i,
  input  logic [DATA_WIDTH-1:0]   op_a_i,
  input  logic [DATA_WIDTH-1:0]   op_b_i,
  output logic                    data_valid_o,
  output logic [2*DATA_WIDTH-1:0] result_o
);

  localparam int unsigned CHUNK = DATA_WIDTH / PIPELINE_DEPTH;
  localparam int unsigned NREG  = PIPELINE_DEPTH - 2;
  localparam int unsigned RW    = 2 * DATA_WIDTH;

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [RW-1:0]         acc;
  } stage_t;

  function automatic logic [RW-1:0] partial(input logic [DATA_WIDTH-1:0] a,
                                            input logic [DATA_WIDTH-1:0] b,
                                            input int unsigned k);
    logic [CHUNK-1:0] c;
    c = b[k*CHUNK +: CHUNK];
    return (RW'(a) * RW'(c)) << (k * CHUNK);
  endfunction

  logic [RW-1:0] first_acc;

  // The first two chunks share the entry step so total latency stays DEPTH-1 with the output register.
  always_comb begin
    first_acc = partial(op_a_i, op_b_i, 0) + partial(op_a_i, op_b_i, 1);
  end

  if (NREG == 0) begin : g_comb
    assign data_valid_o = valid_entry_i;
    assign result_o     = first_acc;
  end else begin : g_pipe
    stage_t st_q [NREG];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        for (int unsigned s = 0; s < NREG; s++) st_q[s] <= '0;
      end else if (clk_en_i) begin
        st_q[0] <= '{valid: valid_entry_i, a: op_a_i, b: op_b_i, acc: first_acc};
        for (int unsigned s = 1; s < NREG; s++) begin
          st_q[s] <= '{valid: st_q[s-1].valid,
                       a:     st_q[s-1].a,
                       b:     st_q[s-1].b,
                       acc:   st_q[s-1].acc + partial(st_q[s-1].a, st_q[s-1].b, s + 1)};
        end
      end
    end

    assign data_valid_o = st_q[NREG-1].valid;
    assign result_o     = st_q[NREG-1].acc
                        + partial(st_q[NREG-1].a, st_q[NREG-1].b, PIPELINE_DEPTH - 1);
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one pipelined multiplier among NUM_REQ requesters with round-robin
// arbitration, id tagging and a stallable response register.
module mul_share_arbiter
  import mul_share_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned PIPELINE_DEPTH = 4,
  parameter int unsigned NUM_REQ        = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_n_i,
  input  logic [NUM_REQ-1:0]                 req_valid_i,
  output logic [NUM_REQ-1:0]                 req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_op_a_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_op_b_i,
  output logic                               rsp_valid_o,
  input  logic                               rsp_ready_i,
  output logic [$clog2(NUM_REQ)-1:0]         rsp_id_o,
  output logic [2*DATA_WIDTH-1:0]            rsp_result_o,
  output logic [$clog2(PIPELINE_DEPTH):0]    inflight_o
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);
  localparam int unsigned IF_W = $clog2(PIPELINE_DEPTH) + 1;
  localparam int unsigned NTAG = PIPELINE_DEPTH - 2;

  // The response register layout comes from the shared package.
  if (DATA_WIDTH != DEF_DATA_WIDTH || NUM_REQ != DEF_NUM_REQ) begin : g_bad_cfg
    $error("mul_share_arbiter: DATA_WIDTH/NUM_REQ must match mul_share_pkg");
  end

  logic                    advance;
  logic                    req_hs;
  logic                    rsp_hs;
  logic [NUM_REQ-1:0]      grant;
  logic [ID_W-1:0]         grant_id;
  logic [ID_W-1:0]         rr_ptr_q;
  logic [DATA_WIDTH-1:0]   sel_a;
  logic [DATA_WIDTH-1:0]   sel_b;
  logic                    mult_valid;
  logic [2*DATA_WIDTH-1:0] mult_result;
  id_t                     tag_out;
  rsp_t                    rsp_q;
  logic [IF_W-1:0]         inflight_q;

  assign advance = !rsp_q.valid || rsp_ready_i;
  assign req_hs  = |grant;
  assign rsp_hs  = rsp_q.valid && rsp_ready_i;

  mul_rr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .PTR_WIDTH (ID_W)
  ) u_arb (
    .req_i   (req_valid_i),
    .ptr_i   (rr_ptr_q),
    .en_i    (advance),
    .grant_o (grant)
  );

  always_comb begin
    grant_id = '0;
    sel_a    = '0;
    sel_b    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_id = ID_W'(i);
        sel_a    = req_op_a_i[i*DATA_WIDTH +: DATA_WIDTH];
        sel_b    = req_op_b_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  pipelined_long_multiplier #(
    .DATA_WIDTH     (DATA_WIDTH),
    .PIPELINE_DEPTH (PIPELINE_DEPTH)
  ) u_mul (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .clk_en_i      (advance),
    .valid_entry_i (req_hs),
    .op_a_i        (sel_a),
    .op_b_i        (sel_b),
    .data_valid_o  (mult_valid),
    .result_o      (mult_result)
  );

  // Tag stages track the multiplier's registered stages; the response register holds the last one.
  if (NTAG == 0) begin : g_tag_direct
    assign tag_out = grant_id;
  end else begin : g_tag_pipe
    id_t tag_q [NTAG];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        for (int unsigned s = 0; s < NTAG; s++) tag_q[s] <= '0;
      end else if (advance) begin
        tag_q[0] <= grant_id;
        for (int unsigned s = 1; s < NTAG; s++) tag_q[s] <= tag_q[s-1];
      end
    end

    assign tag_out = tag_q[NTAG-1];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rsp_q <= '0;
    end else if (advance) begin
      rsp_q <= '{id: tag_out, result: mult_result, valid: mult_valid};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rr_ptr_q <= '0;
    end else if (req_hs) begin
      rr_ptr_q <= (32'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      inflight_q <= '0;
    end else begin
      case ({req_hs, rsp_hs})
        2'b10:   inflight_q <= inflight_q + 1'b1;
        2'b01:   inflight_q <= inflight_q - 1'b1;
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  assign req_ready_o  = grant;
  assign rsp_valid_o  = rsp_q.valid;
  assign rsp_id_o     = rsp_q.id;
  assign rsp_result_o = rsp_q.result;
  assign inflight_o   = inflight_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter (DATA_WIDTH=16, DEPTH=4, NUM_REQ=4)
// with hand-computed expected values.
module tb_mul_share_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [3:0]  req_valid_i;
  logic [3:0]  req_ready_o;
  logic [63:0] req_op_a_i;
  logic [63:0] req_op_b_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [1:0]  rsp_id_o;
  logic [31:0] rsp_result_o;
  logic [2:0]  inflight_o;

  int unsigned errors = 0;
  int unsigned checks = 0;

  mul_share_arbiter #(
    .DATA_WIDTH     (16),
    .PIPELINE_DEPTH (4),
    .NUM_REQ        (4)
  ) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_op_a_i   (req_op_a_i),
    .req_op_b_i   (req_op_b_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_id_o     (rsp_id_o),
    .rsp_result_o (rsp_result_o),
    .inflight_o   (inflight_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    req_valid_i = '0;
    rsp_ready_i = 1'b1;
    rst_n_i     = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic [1:0] id, input logic [31:0] res);
    chk({tag, "_valid"}, 64'(rsp_valid_o), 64'(v));
    if (v) begin
      chk({tag, "_id"}, 64'(rsp_id_o), 64'(id));
      chk({tag, "_result"}, 64'(rsp_result_o), 64'(res));
    end
  endtask

  // Operands for the streaming tests: A_i = i+1, B_i = (i+1)<<8.
  task automatic load_stream_ops();
    for (int i = 0; i < 4; i++) begin
      req_op_a_i[i*16 +: 16] = 16'(i + 1);
      req_op_b_i[i*16 +: 16] = 16'((i + 1) << 8);
    end
  endtask

  logic [31:0] prod [4];
  logic [3:0]  exp_rdy;
  logic [2:0]  exp_if;

  initial begin
    prod[0] = 32'h0000_0100;
    prod[1] = 32'h0000_0400;
    prod[2] = 32'h0000_0900;
    prod[3] = 32'h0000_1000;
    rst_n_i     = 1'b0;
    req_valid_i = '0;
    rsp_ready_i = 1'b1;
    req_op_a_i  = '0;
    req_op_b_i  = '0;

    // Reset state
    #2;
    chk("reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("reset_rsp_id", 64'(rsp_id_o), 64'd0);
    chk("reset_rsp_result", 64'(rsp_result_o), 64'd0);
    chk("reset_inflight", 64'(inflight_o), 64'd0);
    chk("reset_req_ready", 64'(req_ready_o), 64'd0);

    // Single request from requester 2
    do_reset();
    req_valid_i = 4'b0100;
    req_op_a_i[32 +: 16] = 16'h00FF;
    req_op_b_i[32 +: 16] = 16'h0101;
    #2;
    chk("single_ready", 64'(req_ready_o), 64'h4);
    chk("single_inflight0", 64'(inflight_o), 64'd0);
    next_cycle();
    req_valid_i = '0;
    #2;
    chk_rsp("single_c1", 1'b0, 2'd0, 32'd0);
    chk("single_inflight1", 64'(inflight_o), 64'd1);
    next_cycle();
    #2;
    chk_rsp("single_c2", 1'b0, 2'd0, 32'd0);
    next_cycle();
    #2;
    chk_rsp("single_c3", 1'b1, 2'd2, 32'h0000_FFFF);
    chk("single_inflight3", 64'(inflight_o), 64'd1);
    next_cycle();
    #2;
    chk_rsp("single_c4", 1'b0, 2'd0, 32'd0);
    chk("single_inflight4", 64'(inflight_o), 64'd0);

    // All four requesters streaming with rsp_ready held high
    do_reset();
    load_stream_ops();
    for (int t = 0; t < 9; t++) begin
      req_valid_i = (t < 5) ? 4'hF : 4'h0;
      #2;
      exp_rdy = (t < 5) ? 4'(1 << (t % 4)) : 4'h0;
      case (t)
        0: exp_if = 3'd0;
        1: exp_if = 3'd1;
        2: exp_if = 3'd2;
        6: exp_if = 3'd2;
        7: exp_if = 3'd1;
        8: exp_if = 3'd0;
        default: exp_if = 3'd3;
      endcase
      chk($sformatf("stream_ready_t%0d", t), 64'(req_ready_o), 64'(exp_rdy));
      chk($sformatf("stream_inflight_t%0d", t), 64'(inflight_o), 64'(exp_if));
      if (t >= 3 && t <= 7)
        chk_rsp($sformatf("stream_t%0d", t), 1'b1, 2'((t - 3) % 4), prod[(t - 3) % 4]);
      else
        chk_rsp($sformatf("stream_t%0d", t), 1'b0, 2'd0, 32'd0);
      next_cycle();
    end

    // Backpressure: response held for 5 cycles, then drains one per cycle
    do_reset();
    load_stream_ops();
    for (int t = 0; t < 13; t++) begin
      req_valid_i = (t < 9) ? 4'hF : 4'h0;
      rsp_ready_i = (t >= 3 && t <= 7) ? 1'b0 : 1'b1;
      #2;
      if (t < 3)       exp_rdy = 4'(1 << t);
      else if (t == 8) exp_rdy = 4'b1000;
      else             exp_rdy = 4'h0;
      if (t < 3)        exp_if = 3'(t);
      else if (t <= 9)  exp_if = 3'd3;
      else              exp_if = 3'(12 - t);
      chk($sformatf("bp_ready_t%0d", t), 64'(req_ready_o), 64'(exp_rdy));
      chk($sformatf("bp_inflight_t%0d", t), 64'(inflight_o), 64'(exp_if));
      if (t >= 3 && t <= 8)
        chk_rsp($sformatf("bp_t%0d", t), 1'b1, 2'd0, prod[0]);
      else if (t >= 9 && t <= 11)
        chk_rsp($sformatf("bp_t%0d", t), 1'b1, 2'(t - 8), prod[t - 8]);
      else
        chk_rsp($sformatf("bp_t%0d", t), 1'b0, 2'd0, 32'd0);
      next_cycle();
    end

    // Corner operands: all-ones squared, and zero times anything
    do_reset();
    req_op_a_i[0 +: 16]  = 16'hFFFF;
    req_op_b_i[0 +: 16]  = 16'hFFFF;
    req_op_a_i[16 +: 16] = 16'h0000;
    req_op_b_i[16 +: 16] = 16'h1234;
    for (int t = 0; t < 6; t++) begin
      req_valid_i = (t == 0) ? 4'b0001 : (t == 1) ? 4'b0010 : 4'b0000;
      #2;
      if (t == 0) chk("corner_ready0", 64'(req_ready_o), 64'h1);
      if (t == 1) chk("corner_ready1", 64'(req_ready_o), 64'h2);
      if (t == 3)      chk_rsp("corner_ones", 1'b1, 2'd0, 32'hFFFE_0001);
      else if (t == 4) chk_rsp("corner_zero", 1'b1, 2'd1, 32'h0000_0000);
      else if (t >= 2) chk_rsp($sformatf("corner_idle_t%0d", t), 1'b0, 2'd0, 32'd0);
      next_cycle();
    end

    // Round-robin with requesters 0 and 2 only
    do_reset();
    for (int t = 0; t < 4; t++) begin
      req_valid_i = 4'b0101;
      #2;
      chk($sformatf("rr_ready_t%0d", t), 64'(req_ready_o), (t % 2 == 0) ? 64'h1 : 64'h4);
      next_cycle();
    end
    req_valid_i = '0;
    repeat (4) next_cycle();

    // Reset with three products in flight
    do_reset();
    load_stream_ops();
    for (int t = 0; t < 3; t++) begin
      req_valid_i = 4'hF;
      next_cycle();
    end
    req_valid_i = '0;
    #2;
    chk("midrst_pre_valid", 64'(rsp_valid_o), 64'd1);
    chk("midrst_pre_inflight", 64'(inflight_o), 64'd3);
    rst_n_i = 1'b0;
    #1;
    chk("midrst_valid", 64'(rsp_valid_o), 64'd0);
    chk("midrst_id", 64'(rsp_id_o), 64'd0);
    chk("midrst_result", 64'(rsp_result_o), 64'd0);
    chk("midrst_inflight", 64'(inflight_o), 64'd0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    for (int t = 0; t < 10; t++) begin
      #2;
      chk($sformatf("postrst_valid_t%0d", t), 64'(rsp_valid_o), 64'd0);
      next_cycle();
    end
    chk("postrst_inflight", 64'(inflight_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mul_share_arbiter.md
MUL_SHARE_ARBITER -- requirements
Module: mul_share_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: operand width, power of 2.
REQ-002 SHALL have parameter PIPELINE_DEPTH, default 4: depth passed to the shared multiplier; must be >=2 and divide DATA_WIDTH.
REQ-003 SHALL have parameter NUM_REQ, default 4: number of requesters, 2..8.
REQ-004 SHALL have port clk_i, input, 1: clock.
REQ-005 SHALL have port rst_n_i, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid_i, input, NUM_REQ: per-requester request valid.
REQ-007 SHALL have port req_ready_o, output, NUM_REQ: per-requester accept; at most one bit high.
REQ-008 SHALL have port req_op_a_i, input, NUM_REQ x DATA_WIDTH: packed operand A, one slice per requester.
REQ-009 SHALL have port req_op_b_i, input, NUM_REQ x DATA_WIDTH: packed operand B, one slice per requester.
REQ-010 SHALL have port rsp_valid_o, output, 1: response valid.
REQ-011 SHALL have port rsp_ready_i, input, 1: response accept.
REQ-012 SHALL have port rsp_id_o, output, clog2(NUM_REQ): index of the originating requester.
REQ-013 SHALL have port rsp_result_o, output, 2*DATA_WIDTH: unsigned product.
REQ-014 SHALL have port inflight_o, output, clog2(PIPELINE_DEPTH)+1: count of accepted requests not yet delivered.

Function
REQ-015 SHALL instantiate one pipelined_long_multiplier and share it among all requesters; valid_entry_i is driven high only on an accepted request.
REQ-016 SHALL compute advance = !rsp_valid_o | rsp_ready_i, and SHALL drive the multiplier clk_en_i, tag pipeline and output register from advance.
REQ-017 SHALL grant round-robin: search starts at rr_ptr, first req_valid_i bit wins, and req_ready_o is high for that bit only when advance=1.
REQ-018 SHALL update rr_ptr to (granted index+1) mod NUM_REQ only on handshake; otherwise rr_ptr holds.
REQ-019 SHALL drive req_ready_o to all zeros when advance=0; no request is lost or duplicated during a stall.
REQ-020 SHALL carry the requester id in a tag shift register of PIPELINE_DEPTH-1 entries, aligned with the multiplier valid pipeline.
REQ-021 SHALL register multiplier result, data_valid_o and tag into the output register when advance=1.
REQ-022 SHALL assert rsp_valid_o exactly PIPELINE_DEPTH-1 cycles after the handshake cycle when no stall occurs; each stall cycle adds one cycle.
REQ-023 SHALL hold rsp_valid_o, rsp_id_o and rsp_result_o stable while rsp_valid_o=1 and rsp_ready_i=0.
REQ-024 SHALL sustain one handshake per cycle with rsp_ready_i held high, i.e. full throughput.
REQ-025 SHALL increment inflight_o on request handshake and decrement it on response handshake; when both occur in the same cycle it holds; maximum value PIPELINE_DEPTH.
REQ-026 SHALL deliver responses in acceptance order.

Reset
REQ-027 On rst_n_i low, SHALL asynchronously clear rsp_valid_o, rsp_id_o, rsp_result_o, inflight_o, rr_ptr and the tag pipeline to 0; req_ready_o follows from rsp_valid_o=0.
REQ-028 Reset mid-operation SHALL discard all in-flight products; no response is produced for them after reset release.

Structure
REQ-029 SHALL place the id width and the tag/response struct (id, result, valid) in shared package mul_share_pkg.
REQ-030 SHALL implement the round-robin grant as sub-module mul_rr_arbiter, with inputs request vector, pointer and enable, and output a one-hot grant.

Verification
Fixed configuration: DATA_WIDTH=16, DEPTH=4, NUM_REQ=4.
REQ-031 Single request: req 2 presents A=0x00FF, B=0x0101 with rsp_ready_i=1 -> 3 cycles later rsp_valid_o=1, id=2, result=0x0000FFFF.
REQ-032 All four requesters valid continuously with rsp_ready_i=1 -> grants in order 0,1,2,3,0; one response per cycle; ids are in grant order.
REQ-033 Backpressure: rsp_ready_i=0 for 5 cycles with one response pending -> response is held stable, req_ready_o=0, inflight_o=3 and stays constant; on release, the next responses follow one per cycle.
REQ-034 Corner values: A=B=0xFFFF -> result 0xFFFE0001; A=0 with any B -> 0.
REQ-035 Reset asserted with 3 requests in flight -> outputs are 0 immediately; after release, no stale response appears within 10 cycles.
REQ-036 Random traffic over 10k cycles checked against a reference model: every product is correct, order is preserved, and no requester waits more than NUM_REQ-1 grants while its req_valid_i is held.
